next_line_prefetcher: RTL
=========================

// Module: next_line_prefetcher
// PURPOSE
// Prefetch engine serving the prefetch-capable cache controller. On each demand-miss fill
// (prefetch_start) it computes the next sequential line address and fetches that line from
// physical memory when demand traffic is idle. It holds the line in a one-entry buffer and
// presents it to the cache (prefetch_ready) until the cache consumes it in its prefetch state.
// PARAMETERS
// ADDR_W    32   byte address width
// LINE_W    256  cacheline width in bits
// OFFSET_W  5    line offset bits (log2(LINE_W/8))
// INDEX_W   3    set index bits; TAG_W = ADDR_W-INDEX_W-OFFSET_W
// CNT_W     16   width of the statistics counters (saturating)
// PORTS
// clk             in   1       clock
// rst_n           in   1       asynchronous, active-low reset
// prefetch_start  in   1       from cache; high for whole miss-fill; rising edge = trigger
// miss_addr       in   ADDR_W  demand miss address, valid while prefetch_start high
// pf_cancel       in   1       cache: target line already present/dirty; drop prefetch
// pf_taken        in   1       cache wrote buffered line this cycle (its prefetch state)
// prefetch_ready  out  1       buffered line valid, cache may consume
// pf_line         out  LINE_W  buffered line data
// pf_tag          out  TAG_W   tag of buffered line
// pf_index        out  INDEX_W set index of buffered line
// demand_busy     in   1       cache pmem_read|pmem_write; demand owns memory port
// pf_pmem_read    out  1       prefetch read request to arbiter/cacheline adapter
// pf_pmem_addr    out  ADDR_W  line-aligned prefetch address
// pf_pmem_rdata   in   LINE_W  line data from memory
// pf_pmem_resp    in   1       read complete, rdata valid this cycle
// pf_issued_cnt   out  CNT_W   prefetches completed to HOLD
// pf_dropped_cnt  out  CNT_W   triggers ignored/cancelled/suppressed
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE; all outputs 0; counters 0; start edge register 0.
// - Trigger = prefetch_start & ~start_q (start_q registered copy). Level re-assertion is not a trigger.
// - Target = {miss_addr[ADDR_W-1:OFFSET_W]+1, OFFSET_W'b0}. Carry out (miss in last line) ->
//   suppress: no prefetch, pf_dropped_cnt++.
// - States: IDLE, WAIT_BUS, FETCH, HOLD.
//   IDLE: trigger (not suppressed) -> latch target into pf_pmem_addr, go WAIT_BUS.
//   WAIT_BUS: pf_cancel -> IDLE, dropped++. ~demand_busy -> FETCH. Else stay.
//   FETCH: pf_pmem_read=1, pf_pmem_addr held stable until resp. On pf_pmem_resp, latch
//     rdata into pf_line, latch tag/index from address, go HOLD. Next cycle prefetch_ready=1.
//     pf_cancel seen in FETCH sets a sticky flag. At resp, flag set -> discard, IDLE, dropped++.
//     Flag clear -> HOLD, issued++. The bus transfer is never aborted.
//   HOLD: prefetch_ready=1, pf_line/tag/index stable. pf_taken -> IDLE; ready low next cycle.
//     pf_cancel (without pf_taken) -> IDLE, dropped++. pf_taken has priority over pf_cancel.
// - Trigger while not IDLE: ignored, dropped++. The in-flight/held line is unaffected.
// - Trigger in the same cycle HOLD exits via pf_taken: ignored, dropped++. One-entry buffer.
// - pf_pmem_read is never asserted while state!=FETCH. It is only entered when demand_busy=0.
//   Demand requests arriving during FETCH wait (arbiter serialises).
// - Latency: trigger cycle T -> WAIT_BUS at T+1 -> earliest pf_pmem_read at T+2 -> ready at
//   resp+1.
// - Counters saturate at all-ones; no wrap.
// - rst_n asserted mid-FETCH: request drops immediately. A later stale pf_pmem_resp in IDLE is ignored.
// STRUCTURE
// - Package prefetch_pkg: pf_state_t enum (IDLE, WAIT_BUS, FETCH, HOLD); default
//   ADDR_W/LINE_W/OFFSET_W/INDEX_W localparams, shared with the cache datapath tag/index slicing.
// - Single module, no sub-modules: FSM, address incrementer, line buffer, two saturating counters.
// TESTING
// - Basic: miss_addr=0x0000_1234, start held 10 cyc, demand_busy low at T+3, resp 4 cyc later
//   -> pf_pmem_addr=0x0000_1240, ready=1 with tag/index of 0x1240, pf_taken -> ready=0 next cycle.
// - Demand priority: demand_busy=1 for 20 cyc after trigger -> pf_pmem_read stays 0 throughout,
//   asserts the cycle after demand_busy falls.
// - Cancel: pf_cancel in WAIT_BUS -> no pmem read, dropped=1. pf_cancel mid-FETCH -> read completes,
//   ready stays 0, dropped=1, issued=0.
// - Overlap: second trigger (miss_addr=0x2000) while HOLD -> ignored, held line still 0x1240,
//   dropped++. Start held high continuously -> exactly one prefetch.
// - Boundary: miss_addr=0xFFFF_FFE4 -> no pf_pmem_read, dropped=1. Counters forced near max
//   -> saturate at 0xFFFF.
// - Reset: rst_n low during FETCH -> outputs 0 same cycle. Resp after release ignored, ready stays 0.

Source files
------------

// File: rtl/prefetch_pkg.sv
// ============================================================================
// Module   : prefetch_pkg
// Brief    : Shared geometry defaults and FSM state type for the prefetcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

package prefetch_pkg;

    localparam int PF_ADDR_W   = 32;
    localparam int PF_LINE_W   = 256;
    localparam int PF_OFFSET_W = 5;
    localparam int PF_INDEX_W  = 3;
    localparam int PF_TAG_W    = PF_ADDR_W - PF_INDEX_W - PF_OFFSET_W;
    localparam int PF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUS = 2'd1,
        FETCH    = 2'd2,
        HOLD     = 2'd3
    } pf_state_t;

endpackage

`default_nettype wire

// File: rtl/next_line_prefetcher.sv
// ============================================================================
// Module   : next_line_prefetcher
// Brief    : Fetches line N+1 after a demand miss on line N into a one-entry buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module next_line_prefetcher
    import prefetch_pkg::*;
#(
    parameter int ADDR_W   = PF_ADDR_W,
    parameter int LINE_W   = PF_LINE_W,
    parameter int OFFSET_W = PF_OFFSET_W,
    parameter int INDEX_W  = PF_INDEX_W,
    parameter int CNT_W    = PF_CNT_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                prefetch_start,
    input  logic [ADDR_W-1:0]                   miss_addr,
    input  logic                                pf_cancel,
    input  logic                                pf_taken,
    output logic                                prefetch_ready,
    output logic [LINE_W-1:0]                   pf_line,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]  pf_tag,
    output logic [INDEX_W-1:0]                  pf_index,
    input  logic                                demand_busy,
    output logic                                pf_pmem_read,
    output logic [ADDR_W-1:0]                   pf_pmem_addr,
    input  logic [LINE_W-1:0]                   pf_pmem_rdata,
    input  logic                                pf_pmem_resp,
    output logic [CNT_W-1:0]                    pf_issued_cnt,
    output logic [CNT_W-1:0]                    pf_dropped_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam logic [ADDR_W:0] OFF_MASK = {{(ADDR_W-OFFSET_W+1){1'b0}}, {OFFSET_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    pf_state_t           state_q, state_d;
    logic                start_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic                cancel_q, cancel_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    dropped_q, dropped_d;

    logic                trigger;
    logic                suppress;
    logic [ADDR_W:0]     next_line;
    logic                cancel_seen;
    logic                drop_fsm;
    logic                drop_trig;
    logic                issue_inc;
    logic                load_line;
    logic [1:0]          drop_inc;
    logic [CNT_W:0]      dropped_sum;
    logic [CNT_W:0]      issued_sum;

    assign trigger = prefetch_start & ~start_q;

    // Filling the offset with ones before +1 yields the next aligned line;
    // bit ADDR_W is the carry out of the last line of the address space.
    assign next_line = ({1'b0, miss_addr} | OFF_MASK) + ONE;
    assign suppress  = next_line[ADDR_W];

    assign cancel_seen = cancel_q | pf_cancel;
    assign drop_trig   = trigger & ((state_q != IDLE) | suppress);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cancel_d  = cancel_q;
        drop_fsm  = 1'b0;
        issue_inc = 1'b0;
        load_line = 1'b0;
        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (trigger && !suppress) begin
                    addr_d  = next_line[ADDR_W-1:0];
                    state_d = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (pf_cancel) begin
                    drop_fsm = 1'b1;
                    state_d  = IDLE;
                end else if (!demand_busy) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The bus transfer always completes; a cancel only discards it.
                if (pf_pmem_resp) begin
                    cancel_d = 1'b0;
                    if (cancel_seen) begin
                        drop_fsm = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        issue_inc = 1'b1;
                        load_line = 1'b1;
                        state_d   = HOLD;
                    end
                end else begin
                    cancel_d = cancel_seen;
                end
            end
            HOLD: begin
                if (pf_taken) begin
                    state_d = IDLE;
                end else if (pf_cancel) begin
                    drop_fsm = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop_inc    = {1'b0, drop_trig} + {1'b0, drop_fsm};
    assign dropped_sum = {1'b0, dropped_q} + {{(CNT_W-1){1'b0}}, drop_inc};
    assign issued_sum  = {1'b0, issued_q} + {{CNT_W{1'b0}}, issue_inc};
    assign dropped_d   = dropped_sum[CNT_W] ? {CNT_W{1'b1}} : dropped_sum[CNT_W-1:0];
    assign issued_d    = issued_sum[CNT_W]  ? {CNT_W{1'b1}} : issued_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            addr_q    <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            index_q   <= '0;
            cancel_q  <= 1'b0;
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= prefetch_start;
            addr_q    <= addr_d;
            cancel_q  <= cancel_d;
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
            if (load_line) begin
                line_q  <= pf_pmem_rdata;
                tag_q   <= addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
                index_q <= addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
            end
        end
    end

    assign prefetch_ready = (state_q == HOLD);
    assign pf_pmem_read   = (state_q == FETCH);
    assign pf_pmem_addr   = addr_q;
    assign pf_line        = line_q;
    assign pf_tag         = tag_q;
    assign pf_index       = index_q;
    assign pf_issued_cnt  = issued_q;
    assign pf_dropped_cnt = dropped_q;

endmodule

`default_nettype wire
